modular_square_iter: RTL and testbench

- Parametrised iterated modular squarer for the VDF datapath. Computes sq_out = sq_in^(2^T) mod N.
- Modulus N and iteration count T are runtime inputs, latched at start.
- Uses a bit-serial interleaved (radix-2) modular multiplier with a busy/valid handshake, abort, and an optional per-iteration output stream.
- Sits in place of the single-square wrapper inside the MSU when many back-to-back squarings must run without host round-trips.

---
 rtl/modular_square_iter.sv | 170 +++++++++++++++++
 tb/tb_modular_square_iter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modular_square_iter.sv
// Iterated modular squarer: sq_out = sq_in^(2^T) mod N, built on a bit-serial
// radix-2 interleaved modular multiplier (one multiplier bit per clock).
//
// state | meaning
// IDLE  | waiting for start; rejects bad operands, T=0 passes sq_in straight through
// MUL   | one interleaved multiply step per cycle, MSB of A first
// NEXT  | squaring done: publish R, feed it back as A, count down iterations
module modular_square_iter #(
   parameter int MOD_LEN = 1024,
   parameter int ITER_W  = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [MOD_LEN-1:0] sq_in,
   input  logic [MOD_LEN-1:0] modulus,
   input  logic [ITER_W-1:0]  iterations,
   output logic               busy,
   output logic [MOD_LEN-1:0] sq_out,
   output logic               valid,
   output logic [MOD_LEN-1:0] iter_out,
   output logic               iter_valid,
   output logic               err
);

   localparam int BW = (MOD_LEN > 1) ? $clog2(MOD_LEN) : 1;
   localparam logic [BW-1:0] TOP_BIT = BW'(MOD_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_NEXT
   } state_t;

   state_t             state_q, state_d;
   logic [MOD_LEN-1:0] a_q, a_d;
   logic [MOD_LEN-1:0] r_q, r_d;
   logic [MOD_LEN-1:0] n_q, n_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic [ITER_W-1:0]  cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
   logic               iter_valid_q, iter_valid_d;
   logic               err_q, err_d;
   logic [MOD_LEN-1:0] sq_out_q, sq_out_d;
   logic [MOD_LEN-1:0] iter_out_q, iter_out_d;

   // One multiplier step; R<N and A<N keep every intermediate below 2N.
   logic [MOD_LEN:0] n_ext, dbl, t1, addend, sum, t2;

   assign n_ext  = {1'b0, n_q};
   assign dbl    = {r_q, 1'b0};
   assign t1     = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
   assign addend = a_q[bit_q] ? {1'b0, a_q} : '0;
   assign sum    = t1 + addend;
   assign t2     = (sum >= n_ext) ? (sum - n_ext) : sum;

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      r_d          = r_q;
      n_d          = n_q;
      bit_d        = bit_q;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      sq_out_d     = sq_out_q;
      iter_out_d   = iter_out_q;
      valid_d      = 1'b0;
      iter_valid_d = 1'b0;
      err_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if ((modulus <= MOD_LEN'(1)) || (sq_in >= modulus)) begin
                  err_d = 1'b1;
               end else if (iterations == '0) begin
                  sq_out_d = sq_in;
                  valid_d  = 1'b1;
               end else begin
                  a_d     = sq_in;
                  n_d     = modulus;
                  cnt_d   = iterations;
                  r_d     = '0;
                  bit_d   = TOP_BIT;
                  busy_d  = 1'b1;
                  state_d = ST_MUL;
               end
            end
         end
         ST_MUL: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               r_d = t2[MOD_LEN-1:0];
               if (bit_q == '0) begin
                  state_d = ST_NEXT;
               end else begin
                  bit_d = bit_q - 1'b1;
               end
            end
         end
         ST_NEXT: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               a_d          = r_q;
               iter_out_d   = r_q;
               iter_valid_d = 1'b1;
               cnt_d        = cnt_q - ITER_W'(1);
               if (cnt_q == ITER_W'(1)) begin
                  sq_out_d = r_q;
                  valid_d  = 1'b1;
                  busy_d   = 1'b0;
                  state_d  = ST_IDLE;
               end else begin
                  r_d     = '0;
                  bit_d   = TOP_BIT;
                  state_d = ST_MUL;
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         r_q          <= '0;
         n_q          <= '0;
         bit_q        <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         iter_valid_q <= 1'b0;
         err_q        <= 1'b0;
         sq_out_q     <= '0;
         iter_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         r_q          <= r_d;
         n_q          <= n_d;
         bit_q        <= bit_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         iter_valid_q <= iter_valid_d;
         err_q        <= err_d;
         sq_out_q     <= sq_out_d;
         iter_out_q   <= iter_out_d;
      end
   end

   assign busy       = busy_q;
   assign valid      = valid_q;
   assign iter_valid = iter_valid_q;
   assign err        = err_q;
   assign sq_out     = sq_out_q;
   assign iter_out   = iter_out_q;

endmodule

// File: tb/tb_modular_square_iter.sv
// Bench for modular_square_iter at MOD_LEN=8: directed runs push expected pulses
// into queues; a negedge monitor pops and compares them as the DUT emits them.
module tb_modular_square_iter;

   localparam int ML = 8;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          abort;
   logic [ML-1:0] sq_in;
   logic [ML-1:0] modulus;
   logic [IW-1:0] iterations;
   logic          busy;
   logic [ML-1:0] sq_out;
   logic          valid;
   logic [ML-1:0] iter_out;
   logic          iter_valid;
   logic          err;

   modular_square_iter #(.MOD_LEN(ML), .ITER_W(IW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .sq_in     (sq_in),
      .modulus   (modulus),
      .iterations(iterations),
      .busy      (busy),
      .sq_out    (sq_out),
      .valid     (valid),
      .iter_out  (iter_out),
      .iter_valid(iter_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   exp_t q_iter[$];
   exp_t q_fin[$];
   int   q_err[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int modsq(input int a, input int n);
      return (a * a) % n;
   endfunction

   // Push expectations for a start issued at this negedge (cycle 0 = next edge).
   task automatic expect_run(input int x, input int n, input int t, input int kmax, input bit fin);
      int base;
      int v;
      base = cyc;
      v = x;
      for (int k = 1; k <= kmax; k++) begin
         v = modsq(v, n);
         q_iter.push_back('{base + k * (ML + 1) + 1, v});
      end
      if (fin) q_fin.push_back('{base + t * (ML + 1) + 1, v});
   endtask

   task automatic run_start(input int x, input int n, input int t, input int kmax, input bit fin);
      expect_run(x, n, t, kmax, fin);
      sq_in      = ML'(x);
      modulus    = ML'(n);
      iterations = IW'(t);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   exp_t e;
   int   ec;

   always @(negedge clk) begin
      if (iter_valid === 1'b1) begin
         if (q_iter.size() == 0) chk("unexpected_iter_valid", int'(iter_valid), 0);
         else begin
            e = q_iter.pop_front();
            chk("iter_cycle", cyc, e.cyc);
            chk("iter_value", int'(iter_out), e.val);
         end
      end
      if (valid === 1'b1) begin
         if (q_fin.size() == 0) chk("unexpected_valid", int'(valid), 0);
         else begin
            e = q_fin.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("sq_out_value", int'(sq_out), e.val);
         end
         if (iter_valid === 1'b1) chk("iter_out_eq_sq_out", int'(iter_out), int'(sq_out));
      end
      if (err === 1'b1) begin
         if (q_err.size() == 0) chk("unexpected_err", int'(err), 0);
         else begin
            ec = q_err.pop_front();
            chk("err_cycle", cyc, ec);
         end
      end
      while (q_iter.size() > 0 && q_iter[0].cyc < cyc) begin
         e = q_iter.pop_front();
         chk("missed_iter_valid_at", cyc, e.cyc);
      end
      while (q_fin.size() > 0 && q_fin[0].cyc < cyc) begin
         e = q_fin.pop_front();
         chk("missed_valid_at", cyc, e.cyc);
      end
      while (q_err.size() > 0 && q_err[0] < cyc) begin
         ec = q_err.pop_front();
         chk("missed_err_at", cyc, ec);
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_iter_valid"}, int'(iter_valid), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_sq_out"}, int'(sq_out), 0);
      chk({tag, "_iter_out"}, int'(iter_out), 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      sq_in      = '0;
      modulus    = '0;
      iterations = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // x=5, N=251, T=3 -> 25, 123, 69; busy over cycles 1..27
      run_start(5, 251, 3, 3, 1'b1);
      for (int r = 1; r <= 30; r++) begin
         chk("busy_run1", int'(busy), (r <= 27) ? 1 : 0);
         @(negedge clk);
      end

      run_start(12, 13, 1, 1, 1'b1);
      repeat (12) @(negedge clk);
      run_start(0, 13, 2, 2, 1'b1);
      repeat (21) @(negedge clk);

      // T=0 passthrough
      run_start(7, 11, 0, 0, 1'b1);
      for (int r = 1; r <= 5; r++) begin
         chk("busy_t0", int'(busy), 0);
         @(negedge clk);
      end

      // Rejected starts: x>=N, N<2, N=0
      q_err.push_back(cyc + 1);
      run_start(251, 251, 3, 0, 1'b0);
      repeat (3) begin
         chk("busy_rej1", int'(busy), 0);
         chk("sq_out_rej1", int'(sq_out), 7);
         @(negedge clk);
      end
      q_err.push_back(cyc + 1);
      run_start(3, 1, 3, 0, 1'b0);
      repeat (3) begin
         chk("busy_rej2", int'(busy), 0);
         chk("sq_out_rej2", int'(sq_out), 7);
         @(negedge clk);
      end
      q_err.push_back(cyc + 1);
      run_start(0, 0, 2, 0, 1'b0);
      repeat (3) begin
         chk("busy_rej3", int'(busy), 0);
         chk("sq_out_rej3", int'(sq_out), 7);
         @(negedge clk);
      end

      // Interference: ignored start at 5, abort at 15, fresh start at 17
      run_start(5, 251, 3, 1, 1'b0);
      repeat (4) @(negedge clk);
      sq_in = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sq_in = 8'd5;
      repeat (9) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("busy_after_abort", int'(busy), 0);
      chk("sq_out_after_abort", int'(sq_out), 7);
      @(negedge clk);
      run_start(3, 251, 2, 2, 1'b1);
      repeat (22) @(negedge clk);

      // abort together with start in IDLE: start wins
      abort = 1'b1;
      run_start(12, 13, 1, 1, 1'b1);
      abort = 1'b0;
      repeat (12) @(negedge clk);

      // Reset mid-run at cycle 12
      run_start(5, 251, 3, 1, 1'b0);
      repeat (11) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk_all_zero("midrun_reset");
      sq_in      = 8'd5;
      modulus    = 8'd251;
      iterations = 8'd1;
      start      = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("busy_in_reset", int'(busy), 0);
         chk("err_in_reset", int'(err), 0);
      end
      reset_n = 1'b1;
      start   = 1'b0;
      repeat (15) @(negedge clk);
      chk("busy_after_reset", int'(busy), 0);
      chk("sq_out_after_reset", int'(sq_out), 0);

      repeat (3) @(negedge clk);
      chk("pending_iter", q_iter.size(), 0);
      chk("pending_valid", q_fin.size(), 0);
      chk("pending_err", q_err.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
